// File: rtl/ens_vote_argmax_if.sv
// Score-vector input and class-result output handshakes for ens_vote_argmax.
// The parameters must match the ens_vote_argmax instance that uses this bus.
interface ens_vote_argmax_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_BITS  = 2,
    parameter int NUM_ENS     = 4
);
    localparam int SUM_BITS = SCORE_BITS + $clog2(NUM_ENS + 1);
    localparam int IDX_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_CLASSES*SCORE_BITS-1:0] in_scores;
    logic                              out_valid;
    logic                              out_ready;
    logic [IDX_BITS-1:0]               out_class;
    logic [SUM_BITS-1:0]               out_score;

    modport master (
        output in_valid, in_scores, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  in_valid, in_scores, out_ready,
        output in_ready, out_valid, out_class, out_score
    );
endinterface

// File: rtl/ens_vote_argmax.sv
// Sums NUM_ENS per-class score vectors, then scans the sums one class per
// cycle for the argmax (lowest index wins ties) and holds it until taken.
module ens_vote_lane #(
    parameter int SCORE_BITS = 2,
    parameter int SUM_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_en,
    input  logic                  first,
    input  logic [SCORE_BITS-1:0] score,
    output logic [SUM_BITS-1:0]   sum
);
    // The first member reloads, so a finished set never leaks into the next.
    always_ff @(posedge clk) begin
        if (rst)
            sum <= '0;
        else if (acc_en)
            sum <= first ? SUM_BITS'(score) : sum + SUM_BITS'(score);
    end
endmodule

module ens_vote_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_BITS  = 2,
    parameter int NUM_ENS     = 4
) (
    input logic              clk,
    input logic              rst,
    ens_vote_argmax_if.slave bus
);
    localparam int SUM_BITS = SCORE_BITS + $clog2(NUM_ENS + 1);
    localparam int IDX_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int CNT_BITS = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;

    typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

    state_t                                state;
    logic [CNT_BITS-1:0]                   cnt;
    logic [IDX_BITS-1:0]                   idx;
    logic [IDX_BITS-1:0]                   best_idx;
    logic [SUM_BITS-1:0]                   best;
    logic [IDX_BITS-1:0]                   out_class_q;
    logic [SUM_BITS-1:0]                   out_score_q;
    logic [NUM_CLASSES-1:0][SCORE_BITS-1:0] scores;
    logic [NUM_CLASSES-1:0][SUM_BITS-1:0]   sums;
    logic                                  accept;
    logic [SUM_BITS-1:0]                   cur;
    logic                                  take_cur;
    logic [SUM_BITS-1:0]                   nxt_best;
    logic [IDX_BITS-1:0]                   nxt_best_idx;

    assign scores = bus.in_scores;
    assign accept = bus.in_valid && (state == ACCUM);

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
        ens_vote_lane #(
            .SCORE_BITS(SCORE_BITS),
            .SUM_BITS  (SUM_BITS)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .acc_en(accept),
            .first (cnt == '0),
            .score (scores[c]),
            .sum   (sums[c])
        );
    end

    // Strict compare keeps the earlier (lower) index on ties.
    always_comb begin
        cur          = sums[idx];
        take_cur     = (idx == '0) || (cur > best);
        nxt_best     = take_cur ? cur : best;
        nxt_best_idx = take_cur ? idx : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            cnt         <= '0;
            idx         <= '0;
            best        <= '0;
            best_idx    <= '0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == CNT_BITS'(NUM_ENS - 1)) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= SCAN;
                        end else begin
                            cnt <= cnt + CNT_BITS'(1);
                        end
                    end
                end
                SCAN: begin
                    best     <= nxt_best;
                    best_idx <= nxt_best_idx;
                    if (idx == IDX_BITS'(NUM_CLASSES - 1)) begin
                        idx         <= '0;
                        out_class_q <= nxt_best_idx;
                        out_score_q <= nxt_best;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_BITS'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;
endmodule

// File: tb/tb_ens_vote_argmax.sv
// Randomized and directed checks of ens_vote_argmax against a per-set
// sum-and-argmax reference model.
module tb_ens_vote_argmax;
    localparam int NC = 10;
    localparam int SB = 2;
    localparam int NE = 4;
    localparam int W  = NC * SB;
    localparam int SMAX = (1 << SB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    int vecs[NE][NC];
    int gaps[NE];
    int exp_cls, exp_sc;

    always #5 clk = ~clk;

    ens_vote_argmax_if #(.NUM_CLASSES(NC), .SCORE_BITS(SB), .NUM_ENS(NE)) bus ();

    ens_vote_argmax #(.NUM_CLASSES(NC), .SCORE_BITS(SB), .NUM_ENS(NE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input int m);
        logic [W-1:0] f;
        f = '0;
        for (int c = 0; c < NC; c++) f[c*SB +: SB] = SB'(vecs[m][c]);
        return f;
    endfunction

    // Reference: plain per-class totals, then first maximum.
    task automatic ref_result();
        int s[NC];
        for (int c = 0; c < NC; c++) begin
            s[c] = 0;
            for (int m = 0; m < NE; m++) s[c] += vecs[m][c];
        end
        exp_cls = 0;
        exp_sc  = s[0];
        for (int c = 1; c < NC; c++)
            if (s[c] > exp_sc) begin
                exp_cls = c;
                exp_sc  = s[c];
            end
    endtask

    task automatic fill(input int hot, input int hot_sc, input int base);
        for (int m = 0; m < NE; m++) begin
            for (int c = 0; c < NC; c++) vecs[m][c] = (c == hot) ? hot_sc : base;
            gaps[m] = 0;
        end
    endtask

    task automatic fill_rand(input int max_gap);
        for (int m = 0; m < NE; m++) begin
            for (int c = 0; c < NC; c++) vecs[m][c] = int'($urandom_range(SMAX, 0));
            gaps[m] = int'($urandom_range(max_gap, 0));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_scores = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_class", bus.out_class, 0);
        chk("rst_out_score", bus.out_score, 0);
    endtask

    // Present member m after gaps[m] idle cycles; it is taken at the next edge.
    task automatic send_vec(input int m);
        chk("acc_ready", bus.in_ready, 1);
        for (int g = 0; g < gaps[m]; g++) begin
            bus.in_valid  = 1'b0;
            bus.in_scores = W'($urandom);
            @(negedge clk);
            chk("idle_ready", bus.in_ready, 1);
            chk("idle_valid", bus.out_valid, 0);
        end
        bus.in_valid  = 1'b1;
        bus.in_scores = pack(m);
        @(negedge clk);
    endtask

    // Scan takes NC cycles; a junk vector is held on the input meanwhile.
    task automatic scan_phase();
        for (int i = 0; i < NC; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_scores = W'($urandom);
            chk("scan_valid", bus.out_valid, 0);
            chk("scan_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        chk("done_valid", bus.out_valid, 1);
        chk("done_class", bus.out_class, exp_cls);
        chk("done_score", bus.out_score, exp_sc);
    endtask

    task automatic done_phase(input int hold);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_ready", bus.in_ready, 0);
            chk("hold_class", bus.out_class, exp_cls);
            chk("hold_score", bus.out_score, exp_sc);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("hs_valid", bus.out_valid, 0);
        chk("hs_ready", bus.in_ready, 1);
        chk("keep_class", bus.out_class, exp_cls);
        chk("keep_score", bus.out_score, exp_sc);
    endtask

    task automatic run_set(input int hold);
        ref_result();
        for (int m = 0; m < NE; m++) send_vec(m);
        scan_phase();
        done_phase(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_scores = '0;
        do_reset();

        // class 7 wins with in_valid held high, then 20 cycles of backpressure
        fill(7, 3, 1);
        run_set(20);
        chk("t1_class", bus.out_class, 7);
        chk("t1_score", bus.out_score, 12);

        // tie between 2 and 5 keeps the lower index
        fill(2, 3, 0);
        for (int m = 0; m < NE; m++) vecs[m][5] = 3;
        run_set(0);
        chk("tie_class", bus.out_class, 2);

        // gapped input: valid pattern 1,0,0,1,0,1,1
        fill_rand(0);
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 1; gaps[3] = 0;
        run_set(3);

        // back-to-back sets: class 9 then class 0, no carry-over
        fill(9, 3, 0);
        run_set(0);
        chk("b2b1_class", bus.out_class, 9);
        fill(0, 3, 0);
        run_set(0);
        chk("b2b2_class", bus.out_class, 0);
        chk("b2b2_score", bus.out_score, 12);

        // reset after two accepts discards the partial sums
        fill(3, 3, 1);
        run_set(1);
        fill(8, 3, 2);
        send_vec(0);
        send_vec(1);
        do_reset();
        fill(4, 2, 1);
        vecs[1][4] = 3;
        run_set(0);
        chk("rst_acc_class", bus.out_class, 4);
        chk("rst_acc_score", bus.out_score, 9);

        // reset while a result is pending in DONE
        fill(6, 3, 0);
        ref_result();
        for (int m = 0; m < NE; m++) send_vec(m);
        scan_phase();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_valid", bus.out_valid, 0);
        chk("rst_done_ready", bus.in_ready, 1);
        chk("rst_done_class", bus.out_class, 0);

        // randomized sets
        for (int t = 0; t < 30; t++) begin
            fill_rand(3);
            run_set(int'($urandom_range(4, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
